uart_rx_framed: RTL

Parametrised UART receive engine for the serial front end. It replaces the fixed 8-bit, no-parity receiver. It adds configurable data width, optional odd/even parity, 1 or 2 stop bits, input synchronisation, start-bit glitch rejection, framing/parity/overrun detection and a valid/ready output handshake toward the command decoder.

---
 rtl/uart_rx_framed.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver with parity, stop-bit checking and valid/ready output
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-high reset
//   rx            asynchronous serial line, idles high
//   rx_data       received word, LSB first on the line
//   rx_valid      word available, held until rx_valid & rx_ready
//   rx_ready      consumer accepts the word
//   parity_error  parity mismatch on the word in rx_data
//   frame_error   a stop bit of the word in rx_data was sampled low
//   overrun       a completed frame was dropped while rx_valid was held
//   busy          receiver is not idle
module uart_rx_framed #(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_p, frm_p, sample, deliver;
    logic                 rxs;

    assign rxs  = sync[1];
    assign busy = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        deliver = 1'b0;
        sample  = (cnt == '0) && (state != S_IDLE) && (state != S_BREAK);
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = HALF;
                end
            end
            S_BREAK: state_n = rxs ? S_IDLE : S_BREAK;
            default: begin
                cnt_n = sample ? FULL : cnt - CW'(1);
                if (sample) begin
                    case (state)
                        S_START: begin
                            state_n = rxs ? S_IDLE : S_DATA;
                            idx_n   = '0;
                        end
                        S_DATA: begin
                            idx_n = idx + 4'd1;
                            if (idx == 4'(DATA_BITS - 1)) begin
                                state_n = (PARITY != 0) ? S_PAR : S_STOP;
                                idx_n   = '0;
                            end
                        end
                        S_PAR: state_n = S_STOP;
                        S_STOP: begin
                            idx_n = idx + 4'd1;
                            if (idx == 4'(STOP_BITS - 1)) begin
                                // a low final stop bit means the line may be held in break
                                deliver = 1'b1;
                                state_n = rxs ? S_IDLE : S_BREAK;
                                idx_n   = '0;
                            end
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync         <= 2'b11;
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_p        <= 1'b0;
            frm_p        <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync  <= {sync[0], rx};
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (state == S_IDLE) begin
                par_p <= 1'b0;
                frm_p <= 1'b0;
            end
            // right shift: after DATA_BITS samples the first bit sits at the LSB
            if (sample && state == S_DATA) shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (sample && state == S_PAR && rxs != (^shreg ^ ODD)) par_p <= 1'b1;
            if (sample && state == S_STOP && !rxs) frm_p <= 1'b1;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data      <= shreg;
                parity_error <= par_p;
                frame_error  <= frm_p | ~rxs;
                rx_valid     <= 1'b1;
            end else if (deliver) begin
                overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_valid && rx_ready) overrun <= 1'b0;
        end
    end
endmodule
